// File: rtl/acondicionador_pkg.sv
// Shared constants for the button conditioner: channel indices, default debounce
// length and the debounce counter width helper.
package acondicionador_pkg;

    localparam int BTN_RESTART         = 0;
    localparam int BTN_PAUSE           = 1;
    localparam int NUM_BTNS            = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int SYNC_STAGES_DEF     = 2;

    // Enough bits to hold 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/acondicionador_botones_antirrebote.sv
// One button channel: input synchronizer, consecutive-sample debounce counter,
// accepted (stable) level and a rising-edge indication of that level.
module antirrebote
    import acondicionador_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic iClk,
    input  logic iReset,
    input  logic iBtn,
    output logic oEstable,
    output logic oSubida
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_sync;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   estable_q;
    logic                   estable_d;
    logic                   previo_q;

    assign btn_sync = sync_q[SYNC_STAGES-1];

    // The sample that completes the run flips the level and clears the counter,
    // so the counter never exceeds DEBOUNCE_CYCLES-1 and cannot wrap.
    always_comb begin
        cnt_d     = '0;
        estable_d = estable_q;
        if (btn_sync != estable_q) begin
            if (cnt_q == CNT_LAST) begin
                estable_d = btn_sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            estable_q <= 1'b0;
            previo_q  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], iBtn};
            cnt_q     <= cnt_d;
            estable_q <= estable_d;
            previo_q  <= estable_q;
        end
    end

    assign oEstable = estable_q;
    assign oSubida  = estable_q & ~previo_q;

endmodule

// File: rtl/acondicionador_botones.sv
// Restart/pause pushbutton conditioner. Defining PAUSE_TOGGLE_EN turns oPause into
// a press-toggled level (cleared by restart); otherwise it is a press pulse.
module acondicionador_botones
    import acondicionador_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iBtnRestart,
    input  logic       iBtnPause,
    output logic       oRestart,
    output logic       oPause,
    output logic [1:0] oBtnEstable
);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] estable;
    logic [NUM_BTNS-1:0] subida;
    logic                restart_q;
    logic                restart_d;
    logic                pause_q;
    logic                pause_d;

    assign btn_raw[BTN_RESTART] = iBtnRestart;
    assign btn_raw[BTN_PAUSE]   = iBtnPause;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_canal
        antirrebote #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_antirrebote (
            .iClk    (iClk),
            .iReset  (iReset),
            .iBtn    (btn_raw[g]),
            .oEstable(estable[g]),
            .oSubida (subida[g])
        );
    end

    always_comb begin
        restart_d = subida[BTN_RESTART];
`ifdef PAUSE_TOGGLE_EN
        // Restart wins over a pause press landing on the same cycle.
        pause_d = pause_q;
        if (subida[BTN_RESTART]) begin
            pause_d = 1'b0;
        end else if (subida[BTN_PAUSE]) begin
            pause_d = ~pause_q;
        end
`else
        pause_d = subida[BTN_PAUSE];
`endif
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            restart_q <= 1'b0;
            pause_q   <= 1'b0;
        end else begin
            restart_q <= restart_d;
            pause_q   <= pause_d;
        end
    end

    assign oRestart    = restart_q;
    assign oPause      = pause_q;
    assign oBtnEstable = estable;

endmodule

// File: tb/tb_acondicionador_botones.sv
// Bench for acondicionador_botones (DEBOUNCE_CYCLES=4, SYNC_STAGES=2): directed
// scenarios plus random bouncing, all checked against a sample-window model.
module tb_acondicionador_botones;

    localparam int D    = 4;
    localparam int S    = 2;
    localparam int MAXE = 8000;

    logic       iClk = 1'b0;
    logic       iReset;
    logic       iBtnRestart;
    logic       iBtnPause;
    logic       oRestart;
    logic       oPause;
    logic [1:0] oBtnEstable;

    always #5 iClk = ~iClk;

    acondicionador_botones #(
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES    (S)
    ) dut (
        .iClk       (iClk),
        .iReset     (iReset),
        .iBtnRestart(iBtnRestart),
        .iBtnPause  (iBtnPause),
        .oRestart   (oRestart),
        .oPause     (oPause),
        .oBtnEstable(oBtnEstable)
    );

    int total = 0;
    int bad   = 0;
    int n     = 0;

    // History of what was sampled on each rising edge, indexed by edge number.
    logic raw_h [2][MAXE];
    logic rst_h [MAXE];

    logic st_m [2];
    int   last_clr [2];
    int   rise_at [2];
    logic exp_pr  = 1'b0;
    logic exp_pp  = 1'b0;
    logic exp_lvl = 1'b0;

    int pr_cnt  = 0;
    int pp_cnt  = 0;
    int pr_edge = -1;
    int pp_edge = -1;
    int base    = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, n);
        end
    endtask

    // Synchronized value the debouncer compares on edge m: raw from S edges
    // earlier, or 0 if a reset edge fell in between.
    function automatic logic syncv(input int b, input int m);
        if (m - S < 1) return 1'b0;
        for (int k = m - S; k < m; k++) begin
            if (rst_h[k]) return 1'b0;
        end
        return raw_h[b][m - S];
    endfunction

    // Level is accepted when the last D compared samples since the last clear
    // all disagree with the current level.
    task automatic model(input int e);
        logic pr;
        logic pp;
        logic all_diff;
        if (rst_h[e]) begin
            for (int b = 0; b < 2; b++) begin
                st_m[b]     = 1'b0;
                last_clr[b] = e;
                rise_at[b]  = -10;
            end
            exp_pr  = 1'b0;
            exp_pp  = 1'b0;
            exp_lvl = 1'b0;
        end else begin
            pr = (rise_at[0] == e - 1);
            pp = (rise_at[1] == e - 1);
            exp_pr = pr;
`ifdef PAUSE_TOGGLE_EN
            if (pr) exp_lvl = 1'b0;
            else if (pp) exp_lvl = ~exp_lvl;
            exp_pp = exp_lvl;
`else
            exp_pp = pp;
`endif
            for (int b = 0; b < 2; b++) begin
                if (e - D + 1 > last_clr[b]) begin
                    all_diff = 1'b1;
                    for (int m = e - D + 1; m <= e; m++) begin
                        if (syncv(b, m) == st_m[b]) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        st_m[b]     = ~st_m[b];
                        last_clr[b] = e;
                        if (st_m[b]) rise_at[b] = e;
                    end
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic br, input logic bp);
        iReset      = r;
        iBtnRestart = br;
        iBtnPause   = bp;
        @(posedge iClk);
        n++;
        if (n >= MAXE) begin
            $display("FAIL edge_budget: got %0d expected below %0d", n, MAXE);
            bad++;
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "edge budget exhausted");
        end
        rst_h[n]    = r;
        raw_h[0][n] = br;
        raw_h[1][n] = bp;
        model(n);
        #1;
        chk("oRestart", int'(oRestart), int'(exp_pr));
        chk("oPause", int'(oPause), int'(exp_pp));
        chk("oBtnEstable", int'(oBtnEstable), int'({st_m[1], st_m[0]}));
        if (oRestart) begin
            pr_cnt++;
            pr_edge = n;
        end
        if (oPause) begin
            pp_cnt++;
            pp_edge = n;
        end
    endtask

    initial begin
        logic br;
        logic bp;
        for (int b = 0; b < 2; b++) begin
            st_m[b]     = 1'b0;
            last_clr[b] = 0;
            rise_at[b]  = -10;
        end
        raw_h[0][0] = 1'b0;
        raw_h[1][0] = 1'b0;
        rst_h[0]    = 1'b0;

        // Reset, then restart held from edge 10: single pulse after edge 16.
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        chk("reset_estable", int'(oBtnEstable), 0);
        while (n < 9) cyc(1'b0, 1'b0, 1'b0);
        pr_cnt = 0;
        while (n < 30) cyc(1'b0, 1'b1, 1'b0);
        chk("latency_pulse_count", pr_cnt, 1);
        chk("latency_pulse_edge", pr_edge, 16);
        chk("latency_estable0", int'(oBtnEstable[0]), 1);
        repeat (12) cyc(1'b0, 1'b0, 1'b0);

        // Pause bounce 1,0,1,0,1 then held: nothing during bounce, one press.
        pp_cnt = 0;
        base   = n;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        repeat (15) cyc(1'b0, 1'b0, 1'b1);
        chk("bounce_estable1", int'(oBtnEstable[1]), 1);
`ifdef PAUSE_TOGGLE_EN
        chk("bounce_pause_level", int'(oPause), 1);
`else
        chk("bounce_pulse_count", pp_cnt, 1);
        chk("bounce_pulse_edge", pp_edge, base + 11);
`endif
        repeat (12) cyc(1'b0, 1'b0, 1'b0);

        // Long hold, release, press again: two pulses, no auto-repeat.
        pr_cnt = 0;
        repeat (100) cyc(1'b0, 1'b1, 1'b0);
        repeat (20) cyc(1'b0, 1'b0, 1'b0);
        repeat (20) cyc(1'b0, 1'b1, 1'b0);
        repeat (12) cyc(1'b0, 1'b0, 1'b0);
        chk("hold_pulse_count", pr_cnt, 2);

        // Reset mid-debounce at rel edges 13..14, button still held afterwards.
        base   = n;
        pr_cnt = 0;
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        while (n < base + 9) cyc(1'b0, 1'b0, 1'b0);
        while (n < base + 12) cyc(1'b0, 1'b1, 1'b0);
        repeat (2) cyc(1'b1, 1'b1, 1'b0);
        while (n < base + 30) cyc(1'b0, 1'b1, 1'b0);
        chk("midreset_pulse_count", pr_cnt, 1);
        chk("midreset_pulse_edge", pr_edge, base + 21);
        repeat (12) cyc(1'b0, 1'b0, 1'b0);

`ifdef PAUSE_TOGGLE_EN
        for (int k = 0; k < 3; k++) begin
            repeat (8) cyc(1'b0, 1'b0, 1'b1);
            chk("toggle_level", int'(oPause), (k % 2 == 0) ? 1 : 0);
            repeat (8) cyc(1'b0, 1'b0, 1'b0);
        end
        pr_cnt = 0;
        repeat (10) cyc(1'b0, 1'b1, 1'b1);
        chk("sim_restart_count", pr_cnt, 1);
        chk("sim_pause_forced", int'(oPause), 0);
`else
        pr_cnt = 0;
        pp_cnt = 0;
        repeat (10) cyc(1'b0, 1'b1, 1'b1);
        chk("sim_restart_count", pr_cnt, 1);
        chk("sim_pause_count", pp_cnt, 1);
        chk("sim_same_edge", pp_edge, pr_edge);
`endif
        repeat (12) cyc(1'b0, 1'b0, 1'b0);

        // Random bouncing on both buttons with occasional resets.
        br = 1'b0;
        bp = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) br = ~br;
            if ($urandom_range(0, 5) == 0) bp = ~bp;
            cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, br, bp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acondicionador_botones.md
ACONDICIONADOR_BOTONES -- requirements
Module: acondicionador_botones

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL be the number of consecutive stable synchronized samples required to accept a button level change; legal range 2..2^24-1.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL be the synchronizer depth per button input; legal range 2..3.
REQ-003 iClk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 iReset  input  1  SHALL be the reset: synchronous and active-high.
REQ-005 iBtnRestart  input  1  SHALL be the raw asynchronous restart pushbutton, active-high, bouncing.
REQ-006 iBtnPause  input  1  SHALL be the raw asynchronous pause pushbutton, active-high, bouncing.
REQ-007 oRestart  output  1  SHALL be the conditioned restart command for the downstream state machine.
REQ-008 oPause  output  1  SHALL be the conditioned pause command for the downstream state machine.
REQ-009 oBtnEstable  output  2  SHALL be the debounced button levels, bit0 restart, bit1 pause.

Function
REQ-010 Each raw input SHALL pass through a SYNC_STAGES-deep flip-flop synchronizer before any other logic.
REQ-011 Per button: counter SHALL increment each cycle the synchronized level differs from the stable level, and clear to 0 on any cycle they match.
REQ-012 Stable level SHALL take the synchronized value on the edge where the counter reaches DEBOUNCE_CYCLES; counter clears that same edge.
REQ-013 Counter width SHALL be ceil(log2(DEBOUNCE_CYCLES+1)) bits; counter SHALL never wrap.
REQ-014 Bounce shorter than DEBOUNCE_CYCLES samples SHALL produce no stable change and no output activity.
REQ-015 oRestart SHALL be a registered one-cycle pulse on each 0->1 transition of the restart stable level; 1->0 transitions produce nothing.
REQ-016 Latency: with raw input held high from first sampled edge E, the pulse SHALL be high for exactly the cycle after edge E+SYNC_STAGES+DEBOUNCE_CYCLES.
REQ-017 A button held indefinitely SHALL produce exactly one pulse; no auto-repeat.
REQ-018 The two channels SHALL be fully independent; simultaneous presses yield pulses on the same cycle (subject to REQ-023).

Reset
REQ-019 While iReset is high: synchronizers, counters, stable levels, edge registers SHALL clear to 0; oRestart=0, oPause=0, oBtnEstable=2'b00 on the next edge.
REQ-020 Reset mid-debounce SHALL discard the partial count; a button still held after reset release SHALL be treated as a new press and produce one pulse after full latency.

Configuration
REQ-021 Macro PAUSE_TOGGLE_EN SHALL select pause output mode.
REQ-022 Without PAUSE_TOGGLE_EN: oPause SHALL be a one-cycle pulse per pause press, identical in form and latency to oRestart.
REQ-023 With PAUSE_TOGGLE_EN: oPause SHALL be a registered level that toggles on each pause press; a restart pulse SHALL force it to 0 that same cycle, and a simultaneous pause press SHALL be ignored; reset value 0.

Structure
REQ-024 Shared package acondicionador_pkg SHALL hold BTN_RESTART=0, BTN_PAUSE=1 index constants, the default DEBOUNCE_CYCLES value, and the counter-width function.
REQ-025 One sub-module, antirrebote (synchronizer + counter + stable level + rising-edge pulse, one button), SHALL be instantiated twice; the top holds only the pause-mode logic and output registers.

Verification
REQ-026 DEBOUNCE_CYCLES=4, SYNC_STAGES=2: reset, hold iBtnRestart high from edge 10 -> oRestart high only during cycle after edge 16, oBtnEstable[0]=1 thereafter.
REQ-027 DEBOUNCE_CYCLES=4: iBtnPause toggled 1,0,1,0,1 cycle-by-cycle then held high -> no pulse during bounce, exactly one pulse 6 edges after last rising toggle.
REQ-028 Hold iBtnRestart for 100 cycles, release, press again -> exactly two oRestart pulses.
REQ-029 Assert iReset at edge 13 during restart debounce, release at edge 15, button held -> no pulse before edge 21, one pulse after edge 21.
REQ-030 PAUSE_TOGGLE_EN defined: three pause presses -> oPause 1,0,1; then simultaneous restart+pause press -> oRestart pulses, oPause=0.
REQ-031 PAUSE_TOGGLE_EN undefined: simultaneous restart+pause press -> oRestart and oPause each one-cycle pulse on the same cycle.
